// File: rtl/riscv_pkg.sv
// Shared RISC-V front-end definitions: datapath widths, reset PC and the fetch-queue entry layout.
package riscv_pkg;

  localparam int XLEN = 64;
  localparam int ILEN = 32;
  localparam logic [XLEN-1:0] RESET_PC = 64'h0;

  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [ILEN-1:0] instr;
    logic            filled;
  } fq_entry_t;

  // Instructions are word aligned; the two low address bits are forced to zero.
  function automatic logic [XLEN-1:0] align_pc(input logic [XLEN-1:0] pc);
    return {pc[XLEN-1:2], 2'b00};
  endfunction

endpackage

// File: rtl/fetch_queue_chk.sv
// Protocol checker for the fetch queue: flags a memory response when nothing is outstanding.
module fetch_queue_chk #(
  parameter int PW = 3
) (
  input logic          clk,
  input logic          rst,
  input logic          rsp_valid,
  input logic [PW-1:0] alloc_ptr,
  input logic [PW-1:0] fill_ptr,
  input logic [PW-1:0] drop_cnt
);

  // A response is only legal while a live request or a discarded one is pending.
  rsp_has_owner: assert property (@(posedge clk) disable iff (rst)
    !(rsp_valid && (alloc_ptr == fill_ptr) && (drop_cnt == '0)))
    else $error("fetch_queue protocol violation: response with no request outstanding");

endmodule

// File: rtl/fetch_queue.sv
// In-order instruction fetch queue: sequential PC generation, multi-cycle imem port, and
// pc/instr buffering toward decode with redirect flush and stale-response discarding.
module fetch_queue
  import riscv_pkg::*;
#(
  parameter int              XLEN     = riscv_pkg::XLEN,
  parameter int              ILEN     = riscv_pkg::ILEN,
  parameter int              DEPTH    = 4,
  parameter logic [XLEN-1:0] RESET_PC = riscv_pkg::RESET_PC
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     redirect_valid_i,
  input  logic [XLEN-1:0]          redirect_pc_i,
  output logic                     imem_req_valid_o,
  input  logic                     imem_req_ready_i,
  output logic [XLEN-1:0]          imem_addr_o,
  input  logic                     imem_rsp_valid_i,
  input  logic [ILEN-1:0]          imem_rsp_data_i,
  output logic                     id_valid_o,
  input  logic                     id_ready_i,
  output logic [XLEN-1:0]          id_pc_o,
  output logic [ILEN-1:0]          id_instr_o,
  output logic [$clog2(DEPTH):0]   count_o
);

  localparam int              IW      = $clog2(DEPTH);
  localparam int              PW      = IW + 1;
  localparam logic [PW-1:0]   PTR_ONE = PW'(1'b1);
  localparam logic [PW:0]     DEPTH_W = (PW+1)'(DEPTH);
  localparam logic [XLEN-1:0] PC_STEP = XLEN'(3'd4);

  fq_entry_t       entries [DEPTH];
  logic [PW-1:0]   alloc_ptr;
  logic [PW-1:0]   fill_ptr;
  logic [PW-1:0]   head_ptr;
  logic [PW-1:0]   drop_cnt;
  logic [XLEN-1:0] fetch_pc;

  logic [PW-1:0]   count;
  logic [PW:0]     pending;
  logic            req_fire;
  logic            pop;
  fq_entry_t       head_entry;

  assign count      = alloc_ptr - head_ptr;
  // Discarded responses still occupy memory-side slots, so they count against capacity.
  assign pending    = {1'b0, count} + {1'b0, drop_cnt};
  assign head_entry = entries[head_ptr[IW-1:0]];

  assign imem_req_valid_o = !rst && !redirect_valid_i && (pending < DEPTH_W);
  assign imem_addr_o      = fetch_pc;
  assign req_fire         = imem_req_valid_o && imem_req_ready_i;

  assign id_valid_o = head_entry.filled && !redirect_valid_i;
  assign id_pc_o    = head_entry.pc;
  assign id_instr_o = head_entry.instr;
  assign pop        = id_valid_o && id_ready_i;
  assign count_o    = count;

  // Queue storage, pointers, drop counter and fetch PC.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        entries[i] <= '0;
      end
      alloc_ptr <= '0;
      fill_ptr  <= '0;
      head_ptr  <= '0;
      drop_cnt  <= '0;
      fetch_pc  <= RESET_PC;
    end else if (redirect_valid_i) begin
      for (int i = 0; i < DEPTH; i++) begin
        entries[i] <= '0;
      end
      alloc_ptr <= '0;
      fill_ptr  <= '0;
      head_ptr  <= '0;
      // Every request issued but not yet answered becomes a response to throw away.
      drop_cnt  <= drop_cnt + (alloc_ptr - fill_ptr) - PW'(imem_rsp_valid_i);
      fetch_pc  <= align_pc(redirect_pc_i);
    end else begin
      if (pop) begin
        entries[head_ptr[IW-1:0]] <= '0;
        head_ptr <= head_ptr + PTR_ONE;
      end else begin
        head_ptr <= head_ptr;
      end
      if (req_fire) begin
        entries[alloc_ptr[IW-1:0]].pc     <= fetch_pc;
        entries[alloc_ptr[IW-1:0]].instr  <= '0;
        entries[alloc_ptr[IW-1:0]].filled <= 1'b0;
        alloc_ptr <= alloc_ptr + PTR_ONE;
        fetch_pc  <= fetch_pc + PC_STEP;
      end else begin
        alloc_ptr <= alloc_ptr;
        fetch_pc  <= fetch_pc;
      end
      if (imem_rsp_valid_i && (drop_cnt != '0)) begin
        drop_cnt <= drop_cnt - PTR_ONE;
      end else if (imem_rsp_valid_i) begin
        entries[fill_ptr[IW-1:0]].instr  <= imem_rsp_data_i;
        entries[fill_ptr[IW-1:0]].filled <= 1'b1;
        fill_ptr <= fill_ptr + PTR_ONE;
      end else begin
        drop_cnt <= drop_cnt;
        fill_ptr <= fill_ptr;
      end
    end
  end

  fetch_queue_chk #(
    .PW (PW)
  ) u_chk (
    .clk       (clk),
    .rst       (rst),
    .rsp_valid (imem_rsp_valid_i),
    .alloc_ptr (alloc_ptr),
    .fill_ptr  (fill_ptr),
    .drop_cnt  (drop_cnt)
  );

endmodule

// File: tb/tb_fetch_queue.sv
// Directed bench for fetch_queue with an in-order, fixed-latency instruction memory model.
module tb_fetch_queue;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        redirect_valid_i = 1'b0;
  logic [63:0] redirect_pc_i = 64'h0;
  logic        imem_req_valid_o;
  logic        imem_req_ready_i = 1'b0;
  logic [63:0] imem_addr_o;
  logic        imem_rsp_valid_i = 1'b0;
  logic [31:0] imem_rsp_data_i = 32'h0;
  logic        id_valid_o;
  logic        id_ready_i = 1'b1;
  logic [63:0] id_pc_o;
  logic [31:0] id_instr_o;
  logic [2:0]  count_o;

  int compared = 0;
  int mismatched = 0;
  int cyc = 0;
  int lat = 1;
  logic toggle_ready = 1'b0;
  logic ready_manual = 1'b1;

  typedef struct {
    logic [63:0] addr;
    int          due;
  } mreq_t;
  mreq_t mq[$];

  fetch_queue #(.DEPTH(4)) dut (
    .clk              (clk),
    .rst              (rst),
    .redirect_valid_i (redirect_valid_i),
    .redirect_pc_i    (redirect_pc_i),
    .imem_req_valid_o (imem_req_valid_o),
    .imem_req_ready_i (imem_req_ready_i),
    .imem_addr_o      (imem_addr_o),
    .imem_rsp_valid_i (imem_rsp_valid_i),
    .imem_rsp_data_i  (imem_rsp_data_i),
    .id_valid_o       (id_valid_o),
    .id_ready_i       (id_ready_i),
    .id_pc_o          (id_pc_o),
    .id_instr_o       (id_instr_o),
    .count_o          (count_o)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] mem_word(input logic [63:0] a);
    return 32'hC0DE_0000 | {16'h0, a[15:0]};
  endfunction

  // Memory: capture the request that will be accepted at the coming edge.
  initial forever begin
    @(negedge clk);
    if (!rst && imem_req_valid_o && imem_req_ready_i) mq.push_back('{imem_addr_o, cyc + lat});
  end

  // Memory: drive responses in order once their latency has elapsed.
  initial forever begin
    @(posedge clk);
    cyc = cyc + 1;
    #2;
    if (rst) begin
      mq.delete();
      imem_rsp_valid_i = 1'b0;
    end else if (mq.size() > 0 && mq[0].due <= cyc) begin
      imem_rsp_valid_i = 1'b1;
      imem_rsp_data_i  = mem_word(mq[0].addr);
      void'(mq.pop_front());
    end else begin
      imem_rsp_valid_i = 1'b0;
    end
    imem_req_ready_i = toggle_ready ? cyc[0] : ready_manual;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic do_reset(input int l, input logic tog, input logic idr);
    tick();
    rst = 1'b1;
    redirect_valid_i = 1'b0;
    lat = l;
    tick();
    tick();
    id_ready_i = idr;
    toggle_ready = tog;
    ready_manual = 1'b1;
    tick();
    rst = 1'b0;
  endtask

  initial begin
    logic [63:0] exp_pc;
    int pops;
    int wait_cycles;
    logic seen;

    // Reset state.
    tick();
    @(negedge clk);
    chk("rst_req_valid", {63'h0, imem_req_valid_o}, 64'h0);
    chk("rst_id_valid",  {63'h0, id_valid_o}, 64'h0);
    chk("rst_id_pc",     id_pc_o, 64'h0);
    chk("rst_id_instr",  {32'h0, id_instr_o}, 64'h0);
    chk("rst_count",     {61'h0, count_o}, 64'h0);
    chk("rst_addr",      imem_addr_o, 64'h0);

    // Streaming, k=1, decode always ready.
    do_reset(1, 1'b0, 1'b1);
    @(negedge clk);
    chk("rel_req_valid", {63'h0, imem_req_valid_o}, 64'h1);
    chk("rel_addr",      imem_addr_o, 64'h0);
    tick();
    @(negedge clk);
    chk("stream_empty",  {63'h0, id_valid_o}, 64'h0);
    tick();
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      chk("stream_valid", {63'h0, id_valid_o}, 64'h1);
      chk("stream_pc",    id_pc_o, 64'(4 * i));
      chk("stream_instr", {32'h0, id_instr_o}, {32'h0, 32'hC0DE_0000 | 32'(4 * i)});
      chk("stream_count", {61'h0, count_o}, 64'h2);
      tick();
    end

    // Decode stall fills the queue, then drains in order.
    do_reset(1, 1'b0, 1'b0);
    for (int i = 0; i < 10; i++) tick();
    @(negedge clk);
    chk("stall_req_valid", {63'h0, imem_req_valid_o}, 64'h0);
    chk("stall_count",     {61'h0, count_o}, 64'h4);
    chk("stall_head_pc",   id_pc_o, 64'h0);
    tick();
    id_ready_i = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("drain_pc", id_pc_o, 64'(4 * i));
      if (i == 1) chk("drain_req_valid", {63'h0, imem_req_valid_o}, 64'h1);
      tick();
    end

    // k=3 with toggling memory ready: order and capacity.
    do_reset(3, 1'b1, 1'b1);
    exp_pc = 64'h0;
    pops = 0;
    for (int i = 0; i < 80; i++) begin
      @(negedge clk);
      if (id_valid_o && id_ready_i) begin
        chk("slow_pc",    id_pc_o, exp_pc);
        chk("slow_instr", {32'h0, id_instr_o}, {32'h0, mem_word(exp_pc)});
        exp_pc = exp_pc + 64'd4;
        pops++;
      end
      if (count_o == 3'd4) chk("slow_full_block", {63'h0, imem_req_valid_o}, 64'h0);
      tick();
    end
    chk("slow_progress", {63'h0, pops >= 20}, 64'h1);

    // Redirect with two responses in flight (k=3).
    do_reset(3, 1'b0, 1'b1);
    tick();
    tick();
    redirect_valid_i = 1'b1;
    redirect_pc_i = 64'h1002;
    @(negedge clk);
    chk("redir_req_blocked", {63'h0, imem_req_valid_o}, 64'h0);
    chk("redir_no_pop",      {63'h0, id_valid_o}, 64'h0);
    tick();
    redirect_valid_i = 1'b0;
    @(negedge clk);
    chk("redir_addr",   imem_addr_o, 64'h1000);
    chk("redir_req",    {63'h0, imem_req_valid_o}, 64'h1);
    chk("redir_drop2",  {61'h0, dut.drop_cnt}, 64'h2);
    chk("redir_empty0", {63'h0, id_valid_o}, 64'h0);
    tick();
    @(negedge clk);
    chk("redir_drop1",  {61'h0, dut.drop_cnt}, 64'h1);
    chk("redir_empty1", {63'h0, id_valid_o}, 64'h0);
    tick();
    @(negedge clk);
    chk("redir_drop0",  {61'h0, dut.drop_cnt}, 64'h0);
    chk("redir_empty2", {63'h0, id_valid_o}, 64'h0);
    seen = 1'b0;
    wait_cycles = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (id_valid_o) begin
        seen = 1'b1;
        wait_cycles = i;
        break;
      end
    end
    chk("redir_seen",    {63'h0, seen}, 64'h1);
    chk("redir_latency", 64'(wait_cycles), 64'h1);
    chk("redir_first_pc", id_pc_o, 64'h1000);
    chk("redir_first_instr", {32'h0, id_instr_o}, 64'hC0DE_1000);

    // Redirect coinciding with a response and a ready decode (k=1).
    do_reset(1, 1'b0, 1'b1);
    tick();
    tick();
    redirect_valid_i = 1'b1;
    redirect_pc_i = 64'h2003;
    @(negedge clk);
    chk("rr_no_pop",  {63'h0, id_valid_o}, 64'h0);
    chk("rr_no_req",  {63'h0, imem_req_valid_o}, 64'h0);
    tick();
    redirect_valid_i = 1'b0;
    @(negedge clk);
    chk("rr_drop",    {61'h0, dut.drop_cnt}, 64'h0);
    chk("rr_count",   {61'h0, count_o}, 64'h0);
    chk("rr_addr",    imem_addr_o, 64'h2000);
    chk("rr_empty0",  {63'h0, id_valid_o}, 64'h0);
    tick();
    @(negedge clk);
    chk("rr_empty1",  {63'h0, id_valid_o}, 64'h0);
    tick();
    @(negedge clk);
    chk("rr_valid",   {63'h0, id_valid_o}, 64'h1);
    chk("rr_pc",      id_pc_o, 64'h2000);
    chk("rr_instr",   {32'h0, id_instr_o}, 64'hC0DE_2000);
    tick();
    @(negedge clk);
    chk("rr_pc_next", id_pc_o, 64'h2004);

    // Reset mid-stream with a full queue.
    tick();
    id_ready_i = 1'b0;
    for (int i = 0; i < 8; i++) tick();
    @(negedge clk);
    chk("full_count", {61'h0, count_o}, 64'h4);
    chk("full_valid", {63'h0, id_valid_o}, 64'h1);
    tick();
    rst = 1'b1;
    #1;
    chk("mid_rst_count", {61'h0, count_o}, 64'h0);
    chk("mid_rst_valid", {63'h0, id_valid_o}, 64'h0);
    chk("mid_rst_req",   {63'h0, imem_req_valid_o}, 64'h0);
    tick();
    tick();
    rst = 1'b0;
    @(negedge clk);
    chk("post_rst_addr", imem_addr_o, 64'h0);
    chk("post_rst_req",  {63'h0, imem_req_valid_o}, 64'h1);
    chk("post_rst_count", {61'h0, count_o}, 64'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
